// File: rtl/result_capture_pkg.sv
// Shared types, default widths and the saturating-increment helper for result_capture.
package result_capture_pkg;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_STAMP_W = 16;
    localparam int DEFAULT_CNT_W   = 16;
    localparam int SAT_W           = 32;

    typedef struct packed {
        logic [7:0]                 sum;
        logic                       overflow;
        logic [DEFAULT_STAMP_W-1:0] stamp;
    } capture_entry_t;

    // Increment value, holding at 2^width-1 instead of wrapping (width <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input int unsigned      width);
        logic [SAT_W:0] max_s;
        max_s = ({{SAT_W{1'b0}}, 1'b1} << width) - {{SAT_W{1'b0}}, 1'b1};
        if ({1'b0, value} >= max_s) begin
            return value;
        end else begin
            return value + {{(SAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/result_capture_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle. Read data reads zero while empty.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             accepted,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full     = (level_r == LW'(DEPTH));
    assign empty    = (level_r == {LW{1'b0}});
    assign level    = level_r;
    assign accepted = push_ok_s;

    // Handshake qualification: pop only when data exists, push when room or freed this cycle.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && !empty) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && (!full || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Head read, forced to zero while the FIFO holds nothing.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (!empty) begin
            rdata = mem_r[rd_ptr_r];
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    // Storage array; flushing is done by the pointers, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/result_capture.sv
// Timestamped capture of the adder's sum/overflow into a FIFO drained over valid/ready.
// Optional build macro RESULT_CAPTURE_CHANGE_ONLY_EN: push only when {sum, overflow} changes.
module result_capture
    import result_capture_pkg::*;
#(
    parameter  int DEPTH   = DEFAULT_DEPTH,
    parameter  int STAMP_W = DEFAULT_STAMP_W,
    parameter  int CNT_W   = DEFAULT_CNT_W,
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sum,
    input  logic               overflow,
    input  logic               capture_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_sum,
    output logic               out_overflow,
    output logic [STAMP_W-1:0] out_stamp,
    output logic [LVL_W-1:0]   level,
    output logic [CNT_W-1:0]   sample_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic [CNT_W-1:0]   ovf_count
);

    localparam int ENTRY_W = 9 + STAMP_W;

    logic [STAMP_W-1:0] stamp_r;
    logic               prev_ovf_r;
    logic [CNT_W-1:0]   sample_count_r;
    logic [CNT_W-1:0]   drop_count_r;
    logic [CNT_W-1:0]   ovf_count_r;
    logic               push_req_s;
    logic               accepted_s;
    logic               full_s;
    logic               empty_s;
    logic               ovf_rise_s;
    logic               drop_s;
    logic [ENTRY_W-1:0] head_s;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(SAT_W'(value), CNT_W));
    endfunction

`ifdef RESULT_CAPTURE_CHANGE_ONLY_EN
    logic       first_r;
    logic [8:0] last_r;

    // Change-only qualification: first candidate after reset, or a new {sum, overflow}.
    always_comb begin
        push_req_s = 1'b0;
        if (capture_en && (first_r || ({sum, overflow} != last_r))) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
    end

    // Remember the last requested value, even if the FIFO then drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_r <= 1'b1;
            last_r  <= 9'd0;
        end else if (push_req_s) begin
            first_r <= 1'b0;
            last_r  <= {sum, overflow};
        end else begin
            first_r <= first_r;
            last_r  <= last_r;
        end
    end
`else
    // Every candidate cycle requests a push.
    always_comb begin
        push_req_s = 1'b0;
        if (capture_en) begin
            push_req_s = 1'b1;
        end else begin
            push_req_s = 1'b0;
        end
    end
`endif

    // Event qualification for the statistics counters.
    always_comb begin
        ovf_rise_s = 1'b0;
        drop_s     = 1'b0;
        if (capture_en && overflow && !prev_ovf_r) begin
            ovf_rise_s = 1'b1;
        end else begin
            ovf_rise_s = 1'b0;
        end
        if (push_req_s && !accepted_s) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_req_s),
        .pop      (out_ready),
        .wdata    ({sum, overflow, stamp_r}),
        .rdata    (head_s),
        .accepted (accepted_s),
        .full     (full_s),
        .empty    (empty_s),
        .level    (level)
    );

    // Free-running timestamp, overflow history and saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_r        <= {STAMP_W{1'b0}};
            prev_ovf_r     <= 1'b0;
            sample_count_r <= {CNT_W{1'b0}};
            drop_count_r   <= {CNT_W{1'b0}};
            ovf_count_r    <= {CNT_W{1'b0}};
        end else begin
            stamp_r    <= stamp_r + STAMP_W'(1);
            prev_ovf_r <= overflow;
            if (accepted_s) begin
                sample_count_r <= cnt_inc(sample_count_r);
            end else begin
                sample_count_r <= sample_count_r;
            end
            if (drop_s && full_s) begin
                drop_count_r <= cnt_inc(drop_count_r);
            end else begin
                drop_count_r <= drop_count_r;
            end
            if (ovf_rise_s) begin
                ovf_count_r <= cnt_inc(ovf_count_r);
            end else begin
                ovf_count_r <= ovf_count_r;
            end
        end
    end

    assign out_valid    = !empty_s;
    assign out_sum      = head_s[ENTRY_W-1 -: 8];
    assign out_overflow = head_s[STAMP_W];
    assign out_stamp    = head_s[STAMP_W-1:0];
    assign sample_count = sample_count_r;
    assign drop_count   = drop_count_r;
    assign ovf_count    = ovf_count_r;

endmodule

// File: tb/tb_result_capture.sv
// Scoreboard bench for result_capture: expected entries are queued as stimulus is driven.
module tb_result_capture;
    import result_capture_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sum = 8'd0;
    logic        overflow = 1'b0;
    logic        capture_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_sum;
    logic        out_overflow;
    logic [15:0] out_stamp;
    logic [4:0]  level;
    logic [15:0] sample_count;
    logic [15:0] drop_count;
    logic [15:0] ovf_count;

    always #5 clk = ~clk;

    result_capture #(.DEPTH(DEPTH), .STAMP_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sum(sum), .overflow(overflow), .capture_en(capture_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_overflow(out_overflow), .out_stamp(out_stamp), .level(level),
        .sample_count(sample_count), .drop_count(drop_count), .ovf_count(ovf_count)
    );

    capture_entry_t exp_q[$];
    capture_entry_t obs_head;
    capture_entry_t exp_head;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_samples;
    int          exp_drops;
    int          exp_ovf;
    logic        tb_prev_ovf;
    logic [15:0] tb_stamp;
    logic        obs_v;
    logic        model_v;
    logic        popped;
    logic        tb_first;
    logic [8:0]  tb_last;

    // Drive one cycle of stimulus and advance the reference model; no checking here.
    task automatic step(input logic ce, input logic [7:0] s, input logic o, input logic rdy);
        logic           want;
        capture_entry_t e;
        capture_en = ce; sum = s; overflow = o; out_ready = rdy;
        #1;
        obs_v    = out_valid;
        obs_head = {out_sum, out_overflow, out_stamp};
        model_v  = (exp_q.size() > 0);
        popped   = model_v && rdy;
        want     = ce;
`ifdef RESULT_CAPTURE_CHANGE_ONLY_EN
        want = ce && (tb_first || ({s, o} != tb_last));
        if (want) begin
            tb_first = 1'b0;
            tb_last  = {s, o};
        end
`endif
        if (want) begin
            if (exp_q.size() - (popped ? 1 : 0) < DEPTH) begin
                e = {s, o, tb_stamp};
                exp_q.push_back(e);
                exp_samples++;
            end else begin
                exp_drops++;
            end
        end
        if (ce && o && !tb_prev_ovf) exp_ovf++;
        tb_prev_ovf = o;
        tb_stamp    = tb_stamp + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; capture_en = 1'b1; out_ready = 1'b1; sum = 8'hAA; overflow = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0; capture_en = 1'b0; overflow = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        exp_samples = 0; exp_drops = 0; exp_ovf = 0;
        tb_prev_ovf = 1'b0; tb_stamp = 16'd0; tb_first = 1'b1; tb_last = 9'd0;
    endtask

    task automatic test_reset;
        do_reset(2);
        n_cmp++;
        if (out_valid !== 1'b0 || level !== 5'd0 || {out_sum, out_overflow, out_stamp} !== 25'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%0b level=%0d head=%h, expected 0/0/0",
                     out_valid, level, {out_sum, out_overflow, out_stamp});
        end
        n_cmp++;
        if (sample_count !== 16'd0 || drop_count !== 16'd0 || ovf_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0",
                     sample_count, drop_count, ovf_count);
        end
    endtask

    task automatic test_basic_capture;
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            if (i < 4) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
            else       step(1'b0, 8'h00, 1'b0, 1'b1);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL basic_cycle%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
            if (popped) exp_q.delete(0);
        end
        n_cmp++;
        if (sample_count !== 16'd4 || drop_count !== 16'd0 || level !== 5'd0) begin
            n_bad++;
            $display("FAIL basic_counts: samples=%0d drops=%0d level=%0d, expected 4/0/0",
                     sample_count, drop_count, level);
        end
    endtask

    task automatic test_fill_and_drain;
        do_reset(1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL fill_cycle%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
        end
        n_cmp++;
        if (level !== 5'd16 || drop_count !== 16'd4 || sample_count !== 16'(exp_samples)) begin
            n_bad++;
            $display("FAIL fill_full: level=%0d drops=%0d samples=%0d, expected 16/4/%0d",
                     level, drop_count, sample_count, exp_samples);
        end
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL drain_cycle%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
            if (popped) exp_q.delete(0);
        end
        n_cmp++;
        if (level !== 5'd0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: level=%0d valid=%0b, expected 0/0", level, out_valid);
        end
    endtask

    task automatic test_full_push_pop;
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        if (popped) exp_q.delete(0);
        n_cmp++;
        if (level !== 5'd16 || drop_count !== 16'd0 || sample_count !== 16'd17) begin
            n_bad++;
            $display("FAIL full_pushpop: level=%0d drops=%0d samples=%0d, expected 16/0/17",
                     level, drop_count, sample_count);
        end
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL pushpop_drain%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
            if (popped) exp_q.delete(0);
        end
    endtask

    task automatic test_overflow_count;
        logic pat [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h40, pat[i], 1'b1);
            if (popped) exp_q.delete(0);
        end
        n_cmp++;
        if (ovf_count !== 16'd2 || ovf_count !== 16'(exp_ovf)) begin
            n_bad++;
            $display("FAIL ovf_enabled: got %0d, expected 2", ovf_count);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h40, pat[i], 1'b1);
            if (popped) exp_q.delete(0);
        end
        n_cmp++;
        if (ovf_count !== 16'd2) begin
            n_bad++;
            $display("FAIL ovf_disabled: got %0d, expected 2", ovf_count);
        end
    endtask

    task automatic test_mid_reset;
        do_reset(1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (level !== 5'd7) begin
            n_bad++;
            $display("FAIL pre_reset_level: got %0d, expected 7", level);
        end
        do_reset(1);
        n_cmp++;
        if (out_valid !== 1'b0 || level !== 5'd0 || sample_count !== 16'd0 ||
            drop_count !== 16'd0 || ovf_count !== 16'd0 || out_stamp !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset: valid=%0b level=%0d cnt=%0d/%0d/%0d, expected all 0",
                     out_valid, level, sample_count, drop_count, ovf_count);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 0) step(1'b1, 8'h77, 1'b0, 1'b1);
            else        step(1'b0, 8'h00, 1'b0, 1'b1);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL post_reset%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
            if (popped) exp_q.delete(0);
        end
    endtask

    task automatic test_change_only;
        logic [4:0] exp_level;
`ifdef RESULT_CAPTURE_CHANGE_ONLY_EN
        exp_level = 5'd2;
`else
        exp_level = 5'd11;
`endif
        do_reset(1);
        for (int i = 0; i < 11; i++) step(1'b1, (i < 10) ? 8'h55 : 8'h56, 1'b0, 1'b0);
        n_cmp++;
        if (level !== exp_level) begin
            n_bad++;
            $display("FAIL change_only_level: got %0d, expected %0d", level, exp_level);
        end
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            exp_head = model_v ? exp_q[0] : '0;
            n_cmp++;
            if (obs_v !== model_v || obs_head !== exp_head) begin
                n_bad++;
                $display("FAIL change_drain%0d: valid=%0b head=%h, expected valid=%0b head=%h",
                         i, obs_v, obs_head, model_v, exp_head);
            end
            if (popped) exp_q.delete(0);
        end
    endtask

    initial begin
        test_reset;
        test_basic_capture;
        test_fill_and_drain;
        test_full_push_pop;
        test_overflow_count;
        test_mid_reset;
        test_change_only;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
